crc_frame_ctrl: RTL and testbench
=================================

Name: crc_frame_ctrl

Overview:
- Sequential controller that runs CRC encode/check over one frame at a time with a bit-serial long-division engine.
- Encode: accepts a DATA_W-bit word and a (CRC_W+1)-bit generator, returns the remainder and the codeword {data, crc}.
- Check: accepts a received codeword and returns its syndrome plus a pass/fail flag.
- Sits between a word producer and a consumer, both using valid/ready handshakes; one frame in flight.

Parameters:
- DATA_W, 8, payload bits per frame.
- CRC_W, 3, remainder width; the generator is CRC_W+1 bits.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  controller can accept a request.
- mode  in  1  0 = encode, 1 = check.
- data_in  in  DATA_W  payload, MSB transmitted first.
- crc_in  in  CRC_W  received CRC; check mode only, ignored in encode.
- divisor  in  CRC_W+1  generator polynomial, MSB = x^CRC_W term.
- abort  in  1  synchronous abort, returns the controller to IDLE.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- msg  out  DATA_W+CRC_W  codeword {data, crc} in encode; received {data_in, crc_in} in check.
- crc  out  CRC_W  remainder in encode; syndrome in check.
- crc_ok  out  1  check mode: syndrome == 0. Encode mode: 1.
- div_err  out  1  latched divisor MSB was 0; frame not processed.
- busy  out  1  state != IDLE.

Behaviour:
- Reset: asynchronous and active-low. While rst_n = 0:
  - state = IDLE.
  - in_ready = 1, out_valid = 0, busy = 0.
  - msg, crc, crc_ok and div_err = 0.
  - Internal remainder, shift register and counter = 0.
- Reset asserted mid-frame discards the frame immediately.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready, latch mode, data_in, crc_in and divisor.
  - Load the shift register with {data_in, crc_in} in check mode, {data_in, CRC_W zeros} in encode.
  - Clear remainder R and counter.
  - If divisor MSB = 1, go to SHIFT. Otherwise go to DONE with div_err = 1, crc = 0, crc_ok = 0.
- SHIFT:
  - One bit per cycle, MSB first: b = next bit, t = R[CRC_W-1].
  - R <= {R[CRC_W-2:0], b} XOR (t ? divisor[CRC_W-1:0] : 0).
  - Runs exactly DATA_W+CRC_W cycles (11 at defaults); the counter is ceil(log2(DATA_W+CRC_W+1)) bits.
  - On the final bit, go to DONE and register the outputs:
    - crc = next R.
    - msg = {data, next R} in encode; {data, crc_in} in check.
    - crc_ok = (mode == 0) || (next R == 0).
- DONE:
  - out_valid = 1; outputs held stable until out_ready.
  - On out_valid && out_ready, go to IDLE and clear out_valid. msg, crc and crc_ok keep their values until the next DONE.
- Latency: accept edge to out_valid = DATA_W+CRC_W+1 cycles (12 at defaults); 1 cycle for a div_err frame.
- Throughput: one frame per 13 cycles with out_ready held high.
- in_ready = 0 in SHIFT and DONE. in_valid is ignored there and not queued.
- The accept cycle and the DONE-to-IDLE cycle are distinct. No same-cycle pass-through.
- abort:
  - In SHIFT or DONE: next state IDLE, out_valid = 0; partial results discarded and output registers unchanged.
  - In IDLE: no effect. abort has priority over in_valid in the same cycle (no accept).
  - abort and out_ready in the same DONE cycle: treated as abort; the consumer must ignore that result.
- div_err is cleared on the next accept.

Test Plan:
- Encode, data_in = 8'hD3, divisor = 4'b1011 -> out_valid 12 cycles after accept; crc = 3'b011, msg = 11'h69B, crc_ok = 1.
- Check, data_in = 8'hD3, crc_in = 3'b011, divisor = 4'b1011 -> crc = 3'b000, crc_ok = 1. Repeat with crc_in = 3'b010 -> crc = 3'b001, crc_ok = 0.
- Encode, data_in = 8'h00 and data_in = 8'h01, divisor = 4'b1011 -> crc = 3'b000 and crc = 3'b011 respectively.
- Backpressure: hold out_ready = 0 for 5 cycles after out_valid -> msg/crc stable, in_ready = 0, new in_valid ignored. Release -> single handshake, then IDLE.
- divisor = 4'b0011 -> out_valid next cycle, div_err = 1, crc_ok = 0. Next legal frame clears div_err.
- Abort at SHIFT cycle 5, and separately rst_n pulsed low mid-SHIFT -> IDLE, out_valid = 0, no result produced. Back-to-back frame afterwards produces correct results.

Source files
------------

// File: rtl/crc_frame_ctrl_if.sv
// Valid/ready request and result bundle between a word producer, the CRC
// frame controller and the result consumer.
interface crc_frame_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int CRC_W  = 3
);
    logic                    in_valid;
    logic                    in_ready;
    logic                    mode;
    logic [DATA_W-1:0]       data_in;
    logic [CRC_W-1:0]        crc_in;
    logic [CRC_W:0]          divisor;
    logic                    abort;
    logic                    out_valid;
    logic                    out_ready;
    logic [DATA_W+CRC_W-1:0] msg;
    logic [CRC_W-1:0]        crc;
    logic                    crc_ok;
    logic                    div_err;
    logic                    busy;

    modport master (
        output in_valid, mode, data_in, crc_in, divisor, abort, out_ready,
        input  in_ready, out_valid, msg, crc, crc_ok, div_err, busy
    );

    modport slave (
        input  in_valid, mode, data_in, crc_in, divisor, abort, out_ready,
        output in_ready, out_valid, msg, crc, crc_ok, div_err, busy
    );
endinterface

// File: rtl/crc_frame_ctrl.sv
// Bit-serial CRC encode/check controller, one frame in flight.
// state | meaning
// IDLE  | waiting for a request, in_ready high
// SHIFT | dividing one codeword bit per cycle, MSB first
// DONE  | result held with out_valid until out_ready or abort
module crc_frame_ctrl #(
    parameter int DATA_W = 8,
    parameter int CRC_W  = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    crc_frame_ctrl_if.slave  bus
);
    localparam int MSG_W = DATA_W + CRC_W;
    localparam int CNT_W = $clog2(MSG_W + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             state_q;
    logic               mode_q;
    logic [DATA_W-1:0]  data_q;
    logic [CRC_W-1:0]   crc_in_q;
    logic [CRC_W-1:0]   div_q;
    logic [MSG_W-1:0]   sreg_q;
    logic [CRC_W-1:0]   rem_q;
    logic [CRC_W-1:0]   rem_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               out_valid_q;
    logic [MSG_W-1:0]   msg_q;
    logic [CRC_W-1:0]   crc_q;
    logic               crc_ok_q;
    logic               div_err_q;
    logic               last_bit;

    // The generator MSB is implied once the frame is accepted, so only the
    // low CRC_W bits take part in the XOR.
    always_comb begin
        rem_d    = {rem_q[CRC_W-2:0], sreg_q[MSG_W-1]}
                   ^ (rem_q[CRC_W-1] ? div_q : '0);
        last_bit = (cnt_q == CNT_W'(MSG_W - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mode_q      <= 1'b0;
            data_q      <= '0;
            crc_in_q    <= '0;
            div_q       <= '0;
            sreg_q      <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            msg_q       <= '0;
            crc_q       <= '0;
            crc_ok_q    <= 1'b0;
            div_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid && !bus.abort) begin
                        mode_q    <= bus.mode;
                        data_q    <= bus.data_in;
                        crc_in_q  <= bus.crc_in;
                        div_q     <= bus.divisor[CRC_W-1:0];
                        sreg_q    <= bus.mode ? {bus.data_in, bus.crc_in}
                                              : {bus.data_in, {CRC_W{1'b0}}};
                        rem_q     <= '0;
                        cnt_q     <= '0;
                        div_err_q <= ~bus.divisor[CRC_W];
                        if (bus.divisor[CRC_W]) begin
                            state_q <= SHIFT;
                        end else begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                            crc_q       <= '0;
                            crc_ok_q    <= 1'b0;
                        end
                    end
                end
                SHIFT: begin
                    if (bus.abort) begin
                        state_q <= IDLE;
                    end else begin
                        sreg_q <= {sreg_q[MSG_W-2:0], 1'b0};
                        rem_q  <= rem_d;
                        cnt_q  <= cnt_q + 1'b1;
                        if (last_bit) begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                            crc_q       <= rem_d;
                            msg_q       <= mode_q ? {data_q, crc_in_q}
                                                  : {data_q, rem_d};
                            crc_ok_q    <= !mode_q || (rem_d == '0);
                        end
                    end
                end
                DONE: begin
                    if (bus.abort || bus.out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.msg       = msg_q;
    assign bus.crc       = crc_q;
    assign bus.crc_ok    = crc_ok_q;
    assign bus.div_err   = div_err_q;
endmodule

// File: tb/tb_crc_frame_ctrl.sv
// Directed bench for crc_frame_ctrl: expected results are queued at request
// time and compared when the result handshake comes out.
module tb_crc_frame_ctrl;
    localparam int DATA_W = 8;
    localparam int CRC_W  = 3;
    localparam int MSG_W  = DATA_W + CRC_W;

    typedef struct {
        logic [MSG_W-1:0] msg;
        logic [CRC_W-1:0] crc;
        logic             ok;
        logic             derr;
    } exp_t;

    logic clk;
    logic rst_n;
    int   nchk;
    int   npass;
    int   nfail;
    exp_t sb[$];

    crc_frame_ctrl_if #(.DATA_W(DATA_W), .CRC_W(CRC_W)) bus ();

    crc_frame_ctrl #(.DATA_W(DATA_W), .CRC_W(CRC_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain polynomial long division over the whole codeword.
    function automatic exp_t model(input bit m, input logic [7:0] d,
                                   input logic [2:0] c, input logic [3:0] g);
        exp_t e;
        logic [MSG_W-1:0] v;
        if (!g[3]) begin
            e.msg = '0; e.crc = '0; e.ok = 1'b0; e.derr = 1'b1;
            return e;
        end
        v = {d, m ? c : 3'b000};
        for (int i = MSG_W - 1; i >= CRC_W; i--)
            if (v[i]) v = v ^ (MSG_W'(g) << (i - CRC_W));
        e.crc  = v[2:0];
        e.msg  = m ? {d, c} : {d, v[2:0]};
        e.ok   = !m || (v[2:0] == 3'b000);
        e.derr = 1'b0;
        return e;
    endfunction

    function automatic exp_t mk(input logic [10:0] msg, input logic [2:0] crc,
                                input logic ok, input logic derr);
        exp_t e;
        e.msg = msg; e.crc = crc; e.ok = ok; e.derr = derr;
        return e;
    endfunction

    // Ends on the negedge after the accept edge with in_valid dropped.
    task automatic send(input bit m, input logic [7:0] d, input logic [2:0] c,
                        input logic [3:0] g);
        @(negedge clk);
        chk("in_ready_before_accept", 32'(bus.in_ready), 32'd1);
        bus.mode = m; bus.data_in = d; bus.crc_in = c; bus.divisor = g;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Latency counts rising edges from the accept edge to the first edge
    // that sees out_valid high.
    task automatic recv(input int exp_lat, input int hold);
        int   lat;
        exp_t e;
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", 32'(lat), 32'(exp_lat));
        if (!bus.out_valid || sb.size() == 0) begin
            chk("result_available", 32'(bus.out_valid && sb.size() != 0), 32'd1);
            return;
        end
        e = sb.pop_front();
        for (int i = 0; i < hold; i++) begin
            chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
            chk("hold_crc", 32'(bus.crc), 32'(e.crc));
            if (!e.derr) chk("hold_msg", 32'(bus.msg), 32'(e.msg));
            bus.in_valid = 1'b1;
            bus.data_in  = 8'h5A;
            bus.divisor  = 4'b1101;
            @(negedge clk);
            chk("hold_out_valid", 32'(bus.out_valid), 32'd1);
        end
        bus.in_valid = 1'b0;
        if (!e.derr) chk("msg", 32'(bus.msg), 32'(e.msg));
        chk("crc", 32'(bus.crc), 32'(e.crc));
        chk("crc_ok", 32'(bus.crc_ok), 32'(e.ok));
        chk("div_err", 32'(bus.div_err), 32'(e.derr));
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("out_valid_after_hs", 32'(bus.out_valid), 32'd0);
        chk("busy_after_hs", 32'(bus.busy), 32'd0);
    endtask

    task automatic expect_idle_quiet(input string tag, input int cycles);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.out_valid || bus.busy) seen = 1'b1;
        end
        chk(tag, 32'(seen), 32'd0);
    endtask

    initial begin
        logic [2:0] prev_crc;
        logic [7:0] rd;
        logic [2:0] rc;
        logic [3:0] rg;
        bit         rm;
        nchk = 0; npass = 0; nfail = 0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.mode = 1'b0; bus.data_in = '0; bus.crc_in = '0;
        bus.divisor = '0; bus.abort = 1'b0; bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_msg", 32'(bus.msg), 32'd0);
        chk("rst_crc", 32'(bus.crc), 32'd0);
        chk("rst_crc_ok", 32'(bus.crc_ok), 32'd0);
        chk("rst_div_err", 32'(bus.div_err), 32'd0);
        rst_n = 1'b1;

        // Directed vectors with hand-derived results.
        sb.push_back(mk(11'h69B, 3'b011, 1'b1, 1'b0));
        send(1'b0, 8'hD3, 3'b111, 4'b1011); recv(12, 0);
        sb.push_back(mk(11'h69B, 3'b000, 1'b1, 1'b0));
        send(1'b1, 8'hD3, 3'b011, 4'b1011); recv(12, 0);
        sb.push_back(mk(11'h69A, 3'b001, 1'b0, 1'b0));
        send(1'b1, 8'hD3, 3'b010, 4'b1011); recv(12, 0);
        sb.push_back(mk(11'h000, 3'b000, 1'b1, 1'b0));
        send(1'b0, 8'h00, 3'b000, 4'b1011); recv(12, 0);
        sb.push_back(mk(11'h00B, 3'b011, 1'b1, 1'b0));
        send(1'b0, 8'h01, 3'b000, 4'b1011); recv(12, 0);

        // Backpressure: result held five cycles, stray requests ignored.
        sb.push_back(mk(11'h69B, 3'b011, 1'b1, 1'b0));
        send(1'b0, 8'hD3, 3'b000, 4'b1011); recv(12, 5);
        expect_idle_quiet("no_extra_after_backpressure", 15);

        // Illegal generator, then a legal frame clears div_err.
        sb.push_back(mk(11'h000, 3'b000, 1'b0, 1'b1));
        send(1'b0, 8'hD3, 3'b000, 4'b0011); recv(1, 0);
        sb.push_back(mk(11'h00B, 3'b011, 1'b1, 1'b0));
        send(1'b0, 8'h01, 3'b000, 4'b1011); recv(12, 0);

        // Abort in the fifth SHIFT cycle.
        prev_crc = bus.crc;
        send(1'b0, 8'hA7, 3'b000, 4'b1101);
        repeat (4) @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
        chk("abort_crc_kept", 32'(bus.crc), 32'(prev_crc));
        expect_idle_quiet("abort_no_result", 15);

        // Abort wins over a request in IDLE.
        @(negedge clk);
        bus.abort = 1'b1; bus.in_valid = 1'b1; bus.divisor = 4'b1011;
        @(negedge clk);
        bus.abort = 1'b0; bus.in_valid = 1'b0;
        chk("abort_idle_no_accept", 32'(bus.busy), 32'd0);

        // Reset pulse mid-SHIFT.
        send(1'b1, 8'h3C, 3'b101, 4'b1011);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_msg", 32'(bus.msg), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        expect_idle_quiet("midrst_no_result", 15);

        // Back-to-back frames checked against the division model.
        sb.push_back(model(1'b0, 8'hD3, 3'b000, 4'b1011));
        send(1'b0, 8'hD3, 3'b000, 4'b1011); recv(12, 0);
        for (int k = 0; k < 6; k++) begin
            rm = 1'($urandom_range(0, 1));
            rd = 8'($urandom_range(0, 255));
            rc = 3'($urandom_range(0, 7));
            rg = {1'b1, 3'($urandom_range(0, 7))};
            sb.push_back(model(rm, rd, rc, rg));
            send(rm, rd, rc, rg); recv(12, 0);
        end

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
